// File: rtl/fnd_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one conversion in flight.
// Accepts a value on a valid/ready handshake, returns packed BCD, blank mask and overflow.
module fnd_bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  localparam int unsigned     ScrW      = 4 * (DIGITS + 1);
  localparam int unsigned     CntW      = $clog2(BIN_W + 1);
  localparam longint unsigned MaxVal    = pow10(DIGITS) - 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(BIN_W - 1);
  localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0]   MaskRst  = {{(DIGITS - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [ScrW-1:0]     scr_q, scr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                ovf_q, ovf_d;

  logic [ScrW-1:0]     scr_adj;
  logic [ScrW-1:0]     scr_sh;
  logic [BIN_W-1:0]    bin_sh;
  logic [DIGITS-1:0]   mask_calc;
  logic                in_over;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly into the next digit.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < int'(DIGITS + 1); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {scr_sh, bin_sh} = {scr_adj[ScrW-2:0], bin_q, 1'b0};

  // Bit k set when digit k and all digits above it are zero; units digit is never blanked.
  always_comb begin
    logic zero_above;
    mask_calc  = '0;
    zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_above   = zero_above & (scr_sh[4*k +: 4] == 4'd0);
      mask_calc[k] = zero_above;
    end
  end

  assign in_over = 64'(bin_in) > MaxVal;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    mask_d     = mask_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d      = bin_in;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = in_over;
          state_d    = StShift;
        end
      end
      StShift: begin
        scr_d = scr_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (ovf_pend_q) begin
            bcd_d  = AllNines;
            mask_d = '0;
            ovf_d  = 1'b1;
          end else begin
            bcd_d  = scr_sh[4*DIGITS-1:0];
            mask_d = mask_calc;
            ovf_d  = 1'b0;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      mask_q     <= MaskRst;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      mask_q     <= mask_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StShift);
  assign out_valid  = (state_q == StDone);
  assign bcd_out    = bcd_q;
  assign blank_mask = mask_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fnd_bin2bcd_seq.sv
// Scoreboard bench for fnd_bin2bcd_seq: stimulus pushes expected results, a monitor pops and
// compares on each output handshake and also checks latency, handshake timing and stability.
module tb_fnd_bin2bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  mask;
    logic        ovf;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [13:0] bin_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic [3:0]  blank_mask;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_in = 0;
  int   n_out = 0;
  logic bp_hold = 1'b0;
  logic rnd_rdy = 1'b0;

  fnd_bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .bin_in     (bin_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .ovf        (ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int unsigned v);
    exp_t e;
    if (v > 9999) begin
      e.bcd  = 16'h9999;
      e.mask = 4'b0000;
      e.ovf  = 1'b1;
    end else begin
      e.bcd  = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.mask = {v < 1000, v < 100, v < 10, 1'b0};
      e.ovf  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_bcd_out"}, 32'(bcd_out), 32'h0);
    chk({tag, "_blank_mask"}, 32'(blank_mask), 32'b1110);
  endtask

  // Inputs change 1 time unit after the rising edge; acceptance is seen at the falling edge.
  task automatic send(input logic [13:0] v, input exp_t e);
    int w;
    @(posedge PCLK);
    #1;
    in_valid = 1'b1;
    bin_in   = v;
    w        = 0;
    forever begin
      @(negedge PCLK);
      if (in_ready) begin
        sb.push_back(e);
        n_in++;
        break;
      end
      w++;
      if (w > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge PCLK);
    #1;
    in_valid = 1'b0;
    bin_in   = 14'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge PCLK);
      w++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge PCLK);
      #1;
      out_ready = bp_hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor
  initial begin
    logic inflight;
    logic post_hs;
    int   acc_cyc;
    inflight = 1'b0;
    post_hs  = 1'b0;
    acc_cyc  = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        inflight = 1'b0;
        post_hs  = 1'b0;
      end else begin
        if (post_hs) begin
          chk("post_hs_out_valid", 32'(out_valid), 32'd0);
          chk("post_hs_in_ready", 32'(in_ready), 32'd1);
          post_hs = 1'b0;
        end
        if (inflight && !out_valid) begin
          chk("shift_in_ready", 32'(in_ready), 32'd0);
          chk("shift_busy", 32'(busy), 32'd1);
        end
        if (out_valid) begin
          if (inflight) begin
            chk("latency", 32'(cyc - acc_cyc), 32'(BIN_W + 1));
            inflight = 1'b0;
          end
          chk("done_in_ready", 32'(in_ready), 32'd0);
          chk("done_busy", 32'(busy), 32'd0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got bcd %h with no result expected", bcd_out);
          end else begin
            chk("bcd_out", 32'(bcd_out), 32'(sb[0].bcd));
            chk("blank_mask", 32'(blank_mask), 32'(sb[0].mask));
            chk("ovf", 32'(ovf), 32'(sb[0].ovf));
            if (out_ready) begin
              void'(sb.pop_front());
              n_out++;
              post_hs = 1'b1;
            end
          end
        end
        if (in_valid && in_ready) begin
          inflight = 1'b1;
          acc_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  logic [13:0] dv[8];
  exp_t        de[8];

  initial begin
    dv[0] = 14'd1234;  de[0] = '{16'h1234, 4'b0000, 1'b0};
    dv[1] = 14'd7;     de[1] = '{16'h0007, 4'b1110, 1'b0};
    dv[2] = 14'd0;     de[2] = '{16'h0000, 4'b1110, 1'b0};
    dv[3] = 14'd9999;  de[3] = '{16'h9999, 4'b0000, 1'b0};
    dv[4] = 14'd10;    de[4] = '{16'h0010, 4'b1100, 1'b0};
    dv[5] = 14'd10000; de[5] = '{16'h9999, 4'b0000, 1'b1};
    dv[6] = 14'd16383; de[6] = '{16'h9999, 4'b0000, 1'b1};
    dv[7] = 14'd100;   de[7] = '{16'h0100, 4'b1000, 1'b0};

    repeat (3) @(posedge PCLK);
    #1;
    chk_reset("reset");
    PRESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(dv[i], de[i]);
      drain();
    end

    // Back-to-back accepts
    send(14'd42, '{16'h0042, 4'b1100, 1'b0});
    send(14'd305, '{16'h0305, 4'b1000, 1'b0});
    drain();

    // Backpressure: hold the result for 20 cycles, then release
    bp_hold = 1'b1;
    send(14'd1234, '{16'h1234, 4'b0000, 1'b0});
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge PCLK);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (20) @(posedge PCLK);
    #1;
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_bcd", 32'(bcd_out), 32'h1234);
    bp_hold = 1'b0;
    drain();

    // Reset in the middle of a conversion
    send(14'd8191, '{16'h8191, 4'b0000, 1'b0});
    repeat (5) @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    sb.delete();
    n_in--;
    #1;
    chk_reset("mid_reset");
    @(negedge PCLK);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    send(14'd8191, '{16'h8191, 4'b0000, 1'b0});
    drain();

    // Random sweep against the reference model with random gaps and backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int unsigned v;
      repeat ($urandom_range(0, 3)) @(posedge PCLK);
      v = $urandom_range(0, 16383);
      send(14'(v), model(v));
    end
    drain();
    rnd_rdy = 1'b0;

    chk("result_count", 32'(n_out), 32'(n_in));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_bin2bcd_seq.md
Name: fnd_bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble). It sits between the FND APB register block's 14-bit data register and the digit-scan controller, replacing the combinational /1000, %100 dividers. It takes one binary value per valid/ready handshake and returns DIGITS packed BCD nibbles, a leading-zero blank mask and an overflow flag. Small area, fixed latency, one conversion in flight.

Parameters:
BIN_W, 14, binary input width.
DIGITS, 4, number of BCD digits produced. Maximum representable value is 10^DIGITS - 1.

Ports:
PCLK  in  1  system clock; all state changes on its rising edge.
PRESET  in  1  asynchronous, active-high reset.
bin_in  in  BIN_W  unsigned binary value. Sampled only on the input handshake.
in_valid  in  1  producer has a value on bin_in.
in_ready  out  1  block can accept a value; high only in IDLE.
bcd_out  out  4*DIGITS  packed BCD; nibble k = digit k; digit 0 is the units digit in bits [3:0].
blank_mask  out  DIGITS  bit k = 1 means digit k is a leading zero and should be blanked.
ovf  out  1  the input exceeded 10^DIGITS - 1 and bcd_out is saturated.
out_valid  out  1  bcd_out, blank_mask and ovf hold a completed result.
out_ready  in  1  consumer accepts the result.
busy  out  1  high in SHIFT.

Behaviour:
- Reset: asynchronous on PRESET high.
  - State goes to IDLE; in_ready = 1.
  - out_valid, busy and ovf = 0; bcd_out = 0; blank_mask = {DIGITS-1 ones, 0}.
  - Shift register and bit counter are cleared.
  - Reset mid-conversion abandons the conversion; no partial result ever becomes visible.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture bin_in into the binary shift register and clear the BCD scratch register.
  - Record the overflow flag as (bin_in > 10^DIGITS - 1).
  - Counter = 0; go to SHIFT.
- SHIFT, one bit per cycle, MSB first:
  - Every scratch nibble >= 5 gets 3 added.
  - The {scratch, binary} register then shifts left by 1.
  - Counter increments.
  - On the BIN_W-th SHIFT cycle, go to DONE and load the output registers.
  - If the captured overflow flag is set, output all nibbles = 9 and ovf = 1; otherwise output the scratch value and ovf = 0.
- Scratch register width: 4*(DIGITS+1), enough for the 2^BIN_W - 1 intermediate. Only the low DIGITS nibbles are output.
- Latency: out_valid rises on the BIN_W-th rising edge after the acceptance edge. This is 14 cycles at default parameters, independent of value and of overflow.
- blank_mask, computed from the final digits:
  - Bit k = 1 if digit k and all higher digits are 0.
  - Bit 0 is never set, so value 0 shows "0".
  - When ovf = 1, the mask is all 0.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - Outputs stay stable while out_ready = 0 (arbitrary backpressure).
  - On out_valid && out_ready: out_valid falls next edge and the state returns to IDLE.
  - in_ready rises in that same cycle, so the minimum period between accepts is BIN_W + 2 cycles.
- Outputs after handshake: bcd_out, blank_mask and ovf keep their last value until the next conversion completes. The downstream scan controller may use them continuously.
- No new value is accepted in SHIFT or DONE. in_valid there is ignored; the producer must hold it.
- bin_in changing during SHIFT has no effect.
- Widths: all arithmetic is unsigned. The add-3 is a 4-bit add with no carry out, because a nibble <= 9 after the shift.

Test Plan:
- Basic conversion: accept 1234 → after 14 cycles out_valid = 1, bcd_out = 16'h1234, blank_mask = 4'b0000, ovf = 0; in_ready = 0 throughout SHIFT and DONE.
- Leading zeros: 7 → bcd_out = 16'h0007, blank_mask = 4'b1110. 0 → 16'h0000, mask 4'b1110. 9999 → 16'h9999, mask 4'b0000. 10 → 16'h0010, mask 4'b1100.
- Overflow: 10000 and 16383 (max) → bcd_out = 16'h9999, ovf = 1, blank_mask = 0; latency is still 14 cycles.
- Backpressure: hold out_ready = 0 for 20 cycles after completion → outputs stable and in_ready = 0; raise out_ready for one cycle → out_valid = 0 and in_ready = 1 next cycle. Back-to-back accepts of 42 then 305 give 16'h0042 then 16'h0305.
- Reset mid-operation: assert PRESET at SHIFT cycle 6 of 8191 → outputs return to reset values immediately; after release, converting 8191 gives ovf = 0, bcd_out = 16'h8191 (nibble 4 = 0).
- Random sweep: 1000 random inputs in 0..16383, with random in_valid/out_ready gaps → bcd_out matches the reference model and no result is lost or duplicated.
